uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Buffered UART transmitter, the send-side counterpart of the existing UART receive path. It accepts bytes from on-chip logic through a small FIFO and serialises them onto the TTL serial line as 8N1 frames at a fixed baud rate. It sits between the FPGA top level (debug/echo logic) and the RS232 TX pin, so producers can burst several bytes without waiting for the line.

## Interface
Parameters:
- `baud_rate`, 9600: line rate in bits/s.
- `sys_clk_freq`, 12000000: `clk` frequency in Hz.
- `fifo_depth`, 8: FIFO entries; power of two, ≥2.
- Derived: `CLKS_PER_BIT = sys_clk_freq / baud_rate`, integer division truncated; must be ≥2.

Ports:
- `clk`  in  1  master clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `transmit`  in  1  push strobe; `tx_byte` is written when `transmit` is high and `fifo_full` is low.
- `tx_byte`  in  8  byte to enqueue.
- `tx`  out  1  serial line; idles high.
- `is_transmitting`  out  1  high while a frame is on the line.
- `fifo_full`  out  1  count == `fifo_depth`.
- `fifo_empty`  out  1  count == 0.
- `fifo_count`  out  $clog2(fifo_depth)+1  bytes queued, excluding the byte currently being shifted.
- `overflow`  out  1  one-cycle pulse when a push is dropped because the FIFO is full.

## Operation
- Reset values: `tx`=1, `is_transmitting`=0, `fifo_count`=0, `fifo_empty`=1, `fifo_full`=0, `overflow`=0, state IDLE, read/write pointers 0.
- FIFO:
  - Circular buffer; pointers wrap modulo `fifo_depth`.
  - A push is accepted only if count < `fifo_depth`. A pop in the same cycle does not free a slot for that push.
  - Simultaneous accepted push and pop leaves the count unchanged.
  - A push while full raises `overflow` for the next cycle; the data is discarded and FIFO contents are unchanged.
- State machine:
  - Registers: bit counter 0..`CLKS_PER_BIT`-1, data index 0..7, 8-bit shift register.
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into the shift register, clear the bit counter, and go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with index 0.
  - DATA: `tx`=shift[0], LSB first. After each `CLKS_PER_BIT` cycles, shift right. After bit 7, go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. At the end of STOP:
    - if the FIFO is non-empty, pop and go directly to START (no idle gap);
    - otherwise go to IDLE.
- `tx` and `is_transmitting` are registered outputs. `is_transmitting` is high exactly in START, DATA and STOP.
- Reset asserted mid-frame: `tx` returns to 1 immediately (asynchronous), the FIFO is flushed, and the frame is abandoned. No partial frame resumes after reset deasserts.
- A byte popped into the shift register is unaffected by later pushes.

## Timing
- Push accepted at edge k: `fifo_count`/`fifo_empty` update at edge k.
- If IDLE, the pop occurs at edge k+1, where `tx` falls and `is_transmitting` rises. Total latency from push to start bit is 1 cycle.
- Every bit, start and stop included, is held for exactly `CLKS_PER_BIT` cycles. A frame is exactly 10·`CLKS_PER_BIT` cycles.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- `is_transmitting` stays high across back-to-back frames.
- `fifo_full` deasserts on the edge of the pop that frees a slot. A push in the following cycle is accepted.
- `overflow` is high for exactly one cycle per dropped push.

## Test plan
Bench parameters: `sys_clk_freq`=40, `baud_rate`=10 (`CLKS_PER_BIT`=4), `fifo_depth`=4.

- Reset check: hold `rst` for 3 cycles, then release → `tx`=1, `is_transmitting`=0, `fifo_empty`=1, `fifo_count`=0 for 20 idle cycles.
- Single byte: push 0xA5 at edge k → `tx` low at k+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then high 4 cycles. `is_transmitting` falls at k+41.
- Burst: push 0x00, 0xFF, 0x55 on consecutive cycles → three contiguous 40-cycle frames with no gap. The receiving monitor decodes 0x00, 0xFF, 0x55. `fifo_count` sequence is 1,1,2 then decrements at each frame start.
- Overflow: with `tx` busy, push 5 bytes (0x01–0x05) on consecutive cycles. The first byte is popped into the shift register; 0x02–0x05 fill the FIFO. Push a 0x06 on the next cycle → `overflow` pulses once, and 0x06 is never transmitted.
- Full with simultaneous pop: FIFO full while a push coincides with the STOP→START pop → the push is dropped with `overflow`=1, and `fifo_count` becomes 3.
- Reset mid-frame: assert `rst` during data bit 3 of 0x3C with 2 bytes queued → `tx`=1 asynchronously and `fifo_empty`=1. After release, no further activity on `tx`.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter; a push into an idle line starts the start bit one cycle later.
// Frames run back-to-back while bytes are queued; pushes into a full FIFO are dropped and flagged on overflow.
module uart_tx_fifo #(
    parameter int baud_rate    = 9600,
    parameter int sys_clk_freq = 12000000,
    parameter int fifo_depth   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        transmit,
    input  logic [7:0]                  tx_byte,
    output logic                        tx,
    output logic                        is_transmitting,
    output logic                        fifo_full,
    output logic                        fifo_empty,
    output logic [$clog2(fifo_depth):0] fifo_count,
    output logic                        overflow
);

    localparam int CLKS_PER_BIT = sys_clk_freq / baud_rate;
    localparam int PTR_W        = $clog2(fifo_depth);
    localparam int CNT_W        = $clog2(fifo_depth) + 1;
    localparam int BIT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(fifo_depth);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;

    logic [7:0]         mem_q [fifo_depth];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;

    logic               push_ok;
    logic               pop;
    logic               bit_end;

    assign fifo_full       = (count_q == DEPTH_C);
    assign fifo_empty      = (count_q == '0);
    assign fifo_count      = count_q;
    assign overflow        = overflow_q;
    assign tx              = tx_q;
    assign is_transmitting = busy_q;

    // Fullness is judged on the registered count, so a pop never frees a slot for a same-cycle push.
    always_comb begin
        push_ok    = transmit && !fifo_full;
        overflow_d = transmit && fifo_full;
        wr_ptr_d   = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        bit_end   = (bit_cnt_q == BIT_LAST);
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    bit_cnt_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    idx_d     = 3'd0;
                    state_d   = DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    shift_d   = shift_q >> 1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line outputs are derived from the next state so they change on the same edge as the state.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            idx_q      <= 3'd0;
            shift_q    <= 8'd0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= tx_byte;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue/frame-position model, line decoder, directed and random pushes.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       transmit = 1'b0;
    logic [7:0] tx_byte = 8'd0;
    logic       tx, is_transmitting, fifo_full, fifo_empty, overflow;
    logic [2:0] fifo_count;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

    uart_tx_fifo #(
        .baud_rate   (10),
        .sys_clk_freq(40),
        .fifo_depth  (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .transmit       (transmit),
        .tx_byte        (tx_byte),
        .tx             (tx),
        .is_transmitting(is_transmitting),
        .fifo_full      (fifo_full),
        .fifo_empty     (fifo_empty),
        .fifo_count     (fifo_count),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: queued bytes plus the byte on the line and its cycle position within the frame.
    logic [7:0] mq[$];
    logic [7:0] exp_sent[$];
    logic       m_busy = 1'b0;
    int         m_pos = 0;
    logic [7:0] m_cur = 8'd0;
    logic       m_ovf = 1'b0;
    int         m_n;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            exp_sent.delete();
            m_busy = 1'b0;
            m_pos  = 0;
            m_ovf  = 1'b0;
        end else begin
            m_n   = mq.size();
            m_ovf = transmit && (m_n == DEPTH);
            if (m_busy && m_pos < FRAME - 1) begin
                m_pos++;
            end else if (m_n > 0) begin
                m_cur  = mq.pop_front();
                m_busy = 1'b1;
                m_pos  = 0;
                exp_sent.push_back(m_cur);
            end else begin
                m_busy = 1'b0;
            end
            if (transmit && m_n < DEPTH) mq.push_back(tx_byte);
        end
    end

    function automatic logic exp_tx();
        int k;
        if (!m_busy) return 1'b1;
        k = m_pos / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return m_cur[k-1];
    endfunction

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("tx", 32'(tx), 32'(exp_tx()));
            chk("is_transmitting", 32'(is_transmitting), 32'(m_busy));
            chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
            chk("fifo_full", 32'(fifo_full), 32'(mq.size() == DEPTH));
            chk("fifo_empty", 32'(fifo_empty), 32'(mq.size() == 0));
            chk("overflow", 32'(overflow), 32'(m_ovf));
        end
    end

    // Line decoder: finds the start bit, samples mid-bit, checks the stop bit.
    logic       rx_act = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_sh = 8'd0;
    logic [7:0] dec_log[$];

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            rx_act = 1'b0;
        end else if (chk_en) begin
            if (!rx_act) begin
                if (tx == 1'b0) begin
                    rx_act = 1'b1;
                    rx_cnt = 0;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt % 4) == 2) rx_sh[(rx_cnt-6)/4] = tx;
                if (rx_cnt == 38) begin
                    chk("stop_bit", 32'(tx), 32'd1);
                    dec_log.push_back(rx_sh);
                    if (exp_sent.size() == 0) chk("rx_unexpected_byte", 32'(rx_sh), 32'h100);
                    else chk("rx_byte", 32'(rx_sh), 32'(exp_sent.pop_front()));
                end
                if (rx_cnt == 39) rx_act = 1'b0;
            end
        end
    end

    task automatic step(input logic t, input logic [7:0] b);
        @(negedge clk);
        transmit = t;
        tx_byte  = b;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] pat;
        int pct[4];
        pct = '{5, 30, 70, 100};

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        for (int j = 0; j < 20; j++) begin
            step(1'b0, 8'h00);
            chk("rst_tx", 32'(tx), 32'd1);
            chk("rst_busy", 32'(is_transmitting), 32'd0);
            chk("rst_empty", 32'(fifo_empty), 32'd1);
            chk("rst_count", 32'(fifo_count), 32'd0);
        end

        // Single byte 0xA5: frame bits start, 1,0,1,0,0,1,0,1, stop
        pat = 10'b1101001010;
        step(1'b1, 8'hA5);
        for (int j = 0; j <= 44; j++) begin
            step(1'b0, 8'h00);
            if (j == 0) begin
                chk("a5_count", 32'(fifo_count), 32'd1);
                chk("a5_pre_tx", 32'(tx), 32'd1);
            end
            if (j >= 2 && j <= 38 && (j % 4) == 2) chk("a5_bit", 32'(tx), 32'(pat[(j-2)/4]));
            if (j == 40) chk("a5_busy_last", 32'(is_transmitting), 32'd1);
            if (j == 41) chk("a5_busy_fall", 32'(is_transmitting), 32'd0);
        end

        // Burst of three bytes: contiguous frames
        dec_log.delete();
        step(1'b1, 8'h00);
        step(1'b1, 8'hFF);
        chk("burst_cnt0", 32'(fifo_count), 32'd1);
        step(1'b1, 8'h55);
        chk("burst_cnt1", 32'(fifo_count), 32'd1);
        step(1'b0, 8'h00);
        chk("burst_cnt2", 32'(fifo_count), 32'd2);
        for (int j = 3; j <= 130; j++) begin
            step(1'b0, 8'h00);
            if (j == 40) chk("burst_stop_tx", 32'(tx), 32'd1);
            if (j == 41) begin
                chk("burst_next_start", 32'(tx), 32'd0);
                chk("burst_busy_held", 32'(is_transmitting), 32'd1);
                chk("burst_cnt_dec", 32'(fifo_count), 32'd1);
            end
        end
        chk("burst_ndec", 32'(dec_log.size()), 32'd3);
        if (dec_log.size() == 3) begin
            chk("burst_b0", 32'(dec_log[0]), 32'h00);
            chk("burst_b1", 32'(dec_log[1]), 32'hFF);
            chk("burst_b2", 32'(dec_log[2]), 32'h55);
        end

        // Overflow, then a push coinciding with the STOP->START pop while full
        dec_log.delete();
        for (int e = 0; e <= 216; e++) begin
            if (e <= 5) step(1'b1, 8'(e + 1));
            else if (e == 41) step(1'b1, 8'h77);
            else step(1'b0, 8'h00);
            if (e == 5) begin
                chk("ovf_full_cnt", 32'(fifo_count), 32'd4);
                chk("ovf_full", 32'(fifo_full), 32'd1);
                chk("ovf_pre", 32'(overflow), 32'd0);
            end
            if (e == 6) chk("ovf_pulse", 32'(overflow), 32'd1);
            if (e == 7) chk("ovf_drop", 32'(overflow), 32'd0);
            if (e == 41) chk("pop_full_cnt", 32'(fifo_count), 32'd4);
            if (e == 42) begin
                chk("pop_full_ovf", 32'(overflow), 32'd1);
                chk("pop_full_cnt3", 32'(fifo_count), 32'd3);
                chk("pop_full_start", 32'(tx), 32'd0);
            end
        end
        chk("ovf_ndec", 32'(dec_log.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < dec_log.size()) chk("ovf_byte", 32'(dec_log[i]), 32'(i + 1));

        // Reset during data bit 3 of 0x3C with two bytes queued
        dec_log.delete();
        step(1'b1, 8'h3C);
        step(1'b1, 8'h11);
        step(1'b1, 8'h22);
        step(1'b0, 8'h00);
        chk("rstmid_cnt", 32'(fifo_count), 32'd2);
        repeat (16) step(1'b0, 8'h00);
        chk("rstmid_busy", 32'(is_transmitting), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_tx", 32'(tx), 32'd1);
        chk("rstmid_busy0", 32'(is_transmitting), 32'd0);
        chk("rstmid_empty", 32'(fifo_empty), 32'd1);
        chk("rstmid_count", 32'(fifo_count), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 60; j++) begin
            step(1'b0, 8'h00);
            if (j % 10 == 0) begin
                chk("post_rst_tx", 32'(tx), 32'd1);
                chk("post_rst_busy", 32'(is_transmitting), 32'd0);
            end
        end
        chk("post_rst_ndec", 32'(dec_log.size()), 32'd0);

        // Random traffic at several push densities
        for (int ph = 0; ph < 4; ph++)
            for (int c = 0; c < 600; c++)
                step(($urandom_range(0, 99) < pct[ph]), 8'($urandom));
        repeat (400) step(1'b0, 8'h00);
        chk("drain_pending", 32'(exp_sent.size()), 32'd0);
        chk("drain_empty", 32'(fifo_empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
